// File: rtl/ram_arbiter.sv
// Arbitrates the shared RAM port between instruction and data caches with a registered grant.
// Optional macro ARB_FAIRNESS_EN bounds instruction starvation to DSTREAK_MAX data grants.
module ram_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } st_t;

  st_t       st;
  ramstate_t rs;
  logic      dreq;
  logic      ram_done;
  logic      force_i;

  assign rs       = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign ram_done = (rs == ACCESS) || (rs == ERROR);

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned SW = (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(DSTREAK_MAX);

  logic [SW-1:0] dstreak;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SMAX) ? v : v + 1'b1;
  endfunction

  assign force_i = iREN && (dstreak == SMAX);

  // Streak of data completions seen while the instruction side waits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dstreak <= '0;
    end else if (!iREN) begin
      dstreak <= '0;
    end else if ((st == IDLE) && (force_i || !dreq)) begin
      dstreak <= '0;
    end else if ((st == DBUS) && (rs == ACCESS)) begin
      dstreak <= sat_inc(dstreak);
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Grant register: ERROR and abort both fall back to IDLE so the request re-arbitrates
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (force_i)     st <= IBUS;
          else if (dreq)   st <= DBUS;
          else if (iREN)   st <= IBUS;
        end
        IBUS: if (!iREN || ram_done) st <= IDLE;
        DBUS: if (!dreq || ram_done) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  // RAM-side routing follows live requester signals so an abort drops enables at once
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (st)
      IBUS: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DBUS: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = !((st == IBUS) && (rs == ACCESS));
  assign dwait = !((st == DBUS) && (rs == ACCESS));
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
// Vector table plus scoreboard bench for ram_arbiter, with reset, abort and fairness sequences.
module tb_ram_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_iw, e_dw;
  } vec_t;

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, store, load;
    logic        iw, dw;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   kind_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input logic ren, wen, input logic [31:0] addr, store,
                              input logic iw, dw_e);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.e_ren = ren; v.e_wen = wen; v.e_addr = addr;
    v.e_store = store; v.e_iw = iw; v.e_dw = dw_e;
    return v;
  endfunction

  task automatic drive(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                       input logic [1:0] rs, input logic [31:0] rl);
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  initial begin
    int   icomp;
    int   seen;
    exp_t e;
    vec_t v;

    // Reset held with every request asserted
    nRST = 1'b0;
    drive(1, 1, 1, 32'h40, 32'h100, 32'h1234_5678, FREE, 32'h0);
    @(negedge CLK); @(negedge CLK);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);

    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("rel_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    @(negedge CLK);
    chk("grant_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("grant_ramREN", {31'd0, ramREN}, 32'd0);
    chk("grant_ramstore", ramstore, 32'h1234_5678);
    chk("grant_ramaddr", ramaddr, 32'h100);

    // Asynchronous reset in the middle of the data grant
    #2 nRST = 1'b0;
    #1;
    chk("midrst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("midrst_dwait", {31'd0, dwait}, 32'd1);
    @(posedge CLK); #1;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("postrst_ramaddr", ramaddr, 32'd0);

    tbl.push_back(mk(1,1,0, 32'h40,32'h100,0, FREE,0,            0,0,0,0,        1,1));
    tbl.push_back(mk(1,1,0, 32'h40,32'h100,0, BUSY,0,            1,0,32'h100,0,  1,1));
    tbl.push_back(mk(1,1,0, 32'h40,32'h100,0, BUSY,0,            1,0,32'h100,0,  1,1));
    tbl.push_back(mk(1,1,0, 32'h40,32'h100,0, ACC,32'hDEADBEEF,  1,0,32'h100,0,  1,0));
    tbl.push_back(mk(1,0,0, 32'h40,32'h100,0, FREE,0,            0,0,0,0,        1,1));
    tbl.push_back(mk(1,0,0, 32'h40,32'h100,0, ACC,32'hCAFEF00D,  1,0,32'h40,0,   0,1));
    tbl.push_back(mk(0,0,0, 0,0,0, FREE,0,                       0,0,0,0,        1,1));
    tbl.push_back(mk(0,1,1, 0,32'h200,32'h12345678, FREE,0,      0,0,0,0,        1,1));
    tbl.push_back(mk(0,1,1, 0,32'h200,32'h12345678, BUSY,0,      0,1,32'h200,32'h12345678, 1,1));
    tbl.push_back(mk(0,1,1, 0,32'h200,32'h12345678, ACC,0,       0,1,32'h200,32'h12345678, 1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, FREE,0,                       0,0,0,0,        1,1));
    tbl.push_back(mk(1,0,0, 32'h80,0,0, FREE,0,                  0,0,0,0,        1,1));
    tbl.push_back(mk(1,0,0, 32'h80,0,0, ERR,0,                   1,0,32'h80,0,   1,1));
    tbl.push_back(mk(1,0,0, 32'h80,0,0, FREE,0,                  0,0,0,0,        1,1));
    tbl.push_back(mk(1,0,0, 32'h80,0,0, FREE,0,                  1,0,32'h80,0,   1,1));
    tbl.push_back(mk(1,0,0, 32'h80,0,0, ACC,32'h11223344,        1,0,32'h80,0,   0,1));
    tbl.push_back(mk(0,0,0, 0,0,0, FREE,0,                       0,0,0,0,        1,1));
    tbl.push_back(mk(0,1,0, 0,32'h300,0, FREE,0,                 0,0,0,0,        1,1));
    tbl.push_back(mk(0,1,0, 0,32'h300,0, BUSY,0,                 1,0,32'h300,0,  1,1));
    tbl.push_back(mk(0,0,0, 0,32'h300,0, BUSY,0,                 0,0,32'h300,0,  1,1));
    tbl.push_back(mk(0,0,0, 0,32'h300,0, ACC,32'h55,             0,0,0,0,        1,1));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge CLK); #1;
      drive(v.ir, v.dr, v.dw, v.ia, v.da, v.ds, v.rs, v.rl);
      e.ren = v.e_ren; e.wen = v.e_wen; e.addr = v.e_addr; e.store = v.e_store;
      e.load = v.rl; e.iw = v.e_iw; e.dw = v.e_dw;
      sb.push_back(e);
      @(negedge CLK);
      e = sb.pop_front();
      chk($sformatf("v%0d_ramREN", i), {31'd0, ramREN}, {31'd0, e.ren});
      chk($sformatf("v%0d_ramWEN", i), {31'd0, ramWEN}, {31'd0, e.wen});
      chk($sformatf("v%0d_ramaddr", i), ramaddr, e.addr);
      chk($sformatf("v%0d_ramstore", i), ramstore, e.store);
      chk($sformatf("v%0d_iwait", i), {31'd0, iwait}, {31'd0, e.iw});
      chk($sformatf("v%0d_dwait", i), {31'd0, dwait}, {31'd0, e.dw});
      chk($sformatf("v%0d_iload", i), iload, e.load);
      chk($sformatf("v%0d_dload", i), dload, e.load);
    end

    // Continuous data and instruction traffic with a RAM that always answers at once
    @(posedge CLK); #1;
    drive(1, 1, 0, 32'h40, 32'h100, 32'h0, ACC, 32'h0);
`ifdef ARB_FAIRNESS_EN
    kind_q = '{0, 0, 0, 0, 1};
`else
    kind_q = '{0, 0, 0, 0, 0};
`endif
    icomp = 0;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (!iwait) icomp++;
      if ((!iwait || !dwait) && kind_q.size() > 0) begin
        seen++;
        chk($sformatf("fair_comp%0d", seen), {31'd0, !iwait}, kind_q.pop_front());
      end
    end
    chk("fair_all_seen", kind_q.size(), 32'd0);
`ifndef ARB_FAIRNESS_EN
    chk("strict_no_igrant", icomp, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single shared RAM port between the instruction cache and the data cache of the pipelined CPU. It grants one requester at a time through a registered-grant state machine and routes address, store data and load data. It raises per-requester wait signals until the RAM reports `ACCESS`. It sits between the two caches and the RAM model, and replaces direct cache-to-RAM wiring.

## Interface
Parameters:
- `DSTREAK_MAX`, default 4: maximum number of consecutive data grants completed while an instruction request is pending, before the instruction side is forced a grant. Used only with `ARB_FAIRNESS_EN`.

Ports:
- `CLK` in 1: clock; everything is on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: instruction read request.
- `iaddr` in 32 (`word_t`): instruction address.
- `iload` out 32: instruction load data.
- `iwait` out 1: instruction stall.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: data store value.
- `dload` out 32: data load data.
- `dwait` out 1: data stall.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM store value.
- `ramload` in 32: RAM load data.
- `ramstate` in 2 (`ramstate_t`): RAM status, one of `FREE`, `BUSY`, `ACCESS`, `ERROR`.

## Operation
- State register `st` takes one of three values: `IDLE`, `IBUS` or `DBUS`. Reset sets `st`=`IDLE` and `dstreak`=0.
- In `IDLE`:
  - Data request (`dREN|dWEN`) goes to `DBUS`.
  - Otherwise `iREN` goes to `IBUS`.
  - Otherwise stay in `IDLE`.
  - With fairness enabled, if `iREN` is high and `dstreak`==`DSTREAK_MAX`, go to `IBUS` even when a data request is pending.
- Outputs in `IDLE`: `ramREN`=`ramWEN`=0, `ramaddr`=0, `ramstore`=0.
- Outputs in `IBUS`: `ramREN`=`iREN`, `ramWEN`=0, `ramaddr`=`iaddr`, `ramstore`=0.
- Outputs in `DBUS`: `ramWEN`=`dWEN`, `ramREN`=`dREN&~dWEN` (write wins if both are high), `ramaddr`=`daddr`, `ramstore`=`dstore`.
- Completion:
  - In `IBUS`/`DBUS` with `ramstate`==`ACCESS`, the owner's wait is 0 for that cycle. Next state is `IDLE`.
- Abort:
  - If the owner drops its request while in `IBUS`/`DBUS`, the RAM enables drop combinationally. Next state is `IDLE`, with no completion.
- Error:
  - In `IBUS`/`DBUS` with `ramstate`==`ERROR`, the wait stays 1 and next state is `IDLE`.
  - The request is re-arbitrated from `IDLE`, so it retries automatically.
- `FREE`/`BUSY` while owning: hold the state, wait stays 1.
- Wait outputs:
  - `iwait`=1 unless (`st`==`IBUS` and `ramstate`==`ACCESS`).
  - `dwait`=1 unless (`st`==`DBUS` and `ramstate`==`ACCESS`).
  - Both are 1 during and after reset.
- `iload`=`dload`=`ramload`, passed through combinationally. The value is valid only on the owner's completion cycle.
- `dstreak`, a saturating counter of width `$clog2(DSTREAK_MAX+1)`:
  - +1 on a data completion while `iREN` is high.
  - Cleared on entry to `IBUS`.
  - Cleared whenever `iREN` is low.

## Timing
- The grant is registered. A request first seen in `IDLE` at cycle N drives the RAM at cycle N+1.
- Minimum latency is 1 cycle of grant plus 1 cycle for a same-cycle `ACCESS`. Wait is low at N+1 at the earliest.
- There is one mandatory `IDLE` bubble between consecutive transactions. Peak throughput is 1 transaction per 2 cycles.
- The owner must hold address, data and enables stable until its wait drops. Changing the address mid-grant is undefined; dropping the request is the abort path.
- Reset asserted mid-transaction:
  - RAM enables go to 0 immediately (asynchronous clear), and `st`=`IDLE`.
  - No completion is reported.

## Configuration
- `ARB_FAIRNESS_EN` defined: the `dstreak` counter and the forced instruction grant are present. Instruction starvation is bounded to `DSTREAK_MAX` data transactions.
- `ARB_FAIRNESS_EN` undefined: strict data priority. The counter and parameter logic are removed, and `DSTREAK_MAX` is ignored.

## Test plan
- Reset with `nRST`=0 and all requests high -> `ramREN`=`ramWEN`=0, `iwait`=`dwait`=1, `ramaddr`=0; the first grant comes one cycle after release.
- Simultaneous `iREN`=1 `iaddr`=0x40 and `dREN`=1 `daddr`=0x100, with RAM returning `ACCESS` after 2 `BUSY` cycles and `ramload`=0xDEADBEEF:
  - Data is served first (`ramaddr`=0x100, `dload`=0xDEADBEEF, `dwait`=0 on exactly one cycle).
  - After one `IDLE` cycle, `ramaddr`=0x40.
- `dWEN`=`dREN`=1, `dstore`=0x12345678 -> `ramWEN`=1, `ramREN`=0, `ramstore`=0x12345678.
- `ramstate`=`ERROR` during an `IBUS` grant -> `iwait` stays 1, `st` returns to `IDLE`, and `ramREN` re-asserts with the same `iaddr` one cycle later.
- Fairness on, `DSTREAK_MAX`=4, continuous data requests and `iREN` held high -> exactly 4 data completions, then 1 instruction completion. With the macro off, the instruction side is never granted.
- Data owner drops `dREN` during `BUSY` -> `ramREN`=0 that same cycle, no `dwait`=0 pulse, and `IDLE` on the next cycle.
